id_stage_fwd: RTL and testbench

Parametrised instruction-decode stage for the pipelined MIPS core, sitting between the fetch stage and EX. It holds the IF/ID register behind a valid/ready handshake and owns the register file. It forwards operands from a configurable number of downstream stages, and stalls on results that are still pending from multi-cycle loads. It resolves branches and jumps in ID with a one-cycle redirect and squash, and keeps stall/flush performance counters.

---
 rtl/core_pkg.sv | 49 ++++
 rtl/id_decode.sv | 51 +++++
 rtl/id_stage_fwd.sv | 142 ++++++++++++++
 tb/tb_id_stage_fwd.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared MIPS core definitions: opcodes, instruction classes, decode payload, helpers.
package core_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR = 6'h08;

  localparam logic [4:0] REG_RA = 5'd31;

  typedef enum logic [3:0] {
    CL_NONE, CL_R, CL_IARITH, CL_IZEXT, CL_LUI, CL_LW, CL_SW,
    CL_BEQ, CL_BNE, CL_J, CL_JAL, CL_JR
  } inst_class_e;

  // Decoded control for the instruction held in ID; dest 0 means no write.
  typedef struct packed {
    logic       uses_rs;
    logic       uses_rt;
    logic [4:0] dest;
    logic       sext;
    logic       br;
    logic       bne;
    logic       j;
    logic       jal;
    logic       jr;
  } dec_t;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned v = n - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/id_decode.sv
// Combinational instruction decoder for the ID stage.
module id_decode
  import core_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic [4:0] rt,
  input  logic [4:0] rd,
  output dec_t       dec
);

  inst_class_e cls;

  // Classify the instruction by opcode (and funct for jr)
  always_comb begin
    cls = CL_NONE;
    case (op)
      OP_RTYPE:                           cls = (funct == FN_JR) ? CL_JR : CL_R;
      OP_J:                               cls = CL_J;
      OP_JAL:                             cls = CL_JAL;
      OP_BEQ:                             cls = CL_BEQ;
      OP_BNE:                             cls = CL_BNE;
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU: cls = CL_IARITH;
      OP_ANDI, OP_ORI, OP_XORI:           cls = CL_IZEXT;
      OP_LUI:                             cls = CL_LUI;
      OP_LW:                              cls = CL_LW;
      OP_SW:                              cls = CL_SW;
      default:                            cls = CL_NONE;
    endcase
  end

  // Map class to operand usage, destination and control flags
  always_comb begin
    dec      = '0;
    dec.sext = 1'b1;
    case (cls)
      CL_R:              begin dec.uses_rs = 1'b1; dec.uses_rt = 1'b1; dec.dest = rd; end
      CL_IARITH, CL_LW:  begin dec.uses_rs = 1'b1; dec.dest = rt; end
      CL_IZEXT:          begin dec.uses_rs = 1'b1; dec.dest = rt; dec.sext = 1'b0; end
      CL_LUI:            dec.dest = rt;
      CL_SW:             begin dec.uses_rs = 1'b1; dec.uses_rt = 1'b1; end
      CL_BEQ:            begin dec.uses_rs = 1'b1; dec.uses_rt = 1'b1; dec.br = 1'b1; end
      CL_BNE:            begin dec.uses_rs = 1'b1; dec.uses_rt = 1'b1; dec.bne = 1'b1; end
      CL_J:              dec.j = 1'b1;
      CL_JAL:            begin dec.jal = 1'b1; dec.dest = REG_RA; end
      CL_JR:             begin dec.uses_rs = 1'b1; dec.jr = 1'b1; end
      default:           ;
    endcase
  end

endmodule

// File: rtl/id_stage_fwd.sv
// Decode stage: IF/ID register, register file, operand forwarding, branch resolution, perf counters.
module id_stage_fwd
  import core_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned NREG = 32,
  parameter int unsigned NFWD = 3,
  parameter int unsigned AW   = clog2(NREG)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 if_valid,
  output logic                 if_ready,
  input  logic [31:0]          if_inst,
  input  logic [XLEN-1:0]      if_pc4,
  output logic                 id_valid,
  input  logic                 ex_ready,
  input  logic [NFWD-1:0]      fwd_wen,
  input  logic [NFWD-1:0]      fwd_pend,
  input  logic [NFWD*AW-1:0]   fwd_dest,
  input  logic [NFWD*XLEN-1:0] fwd_data,
  input  logic                 wb_wen,
  input  logic [AW-1:0]        wb_dest,
  input  logic [XLEN-1:0]      wb_data,
  output logic [31:0]          id_inst,
  output logic [XLEN-1:0]      id_pc4,
  output logic [XLEN-1:0]      id_rs_val,
  output logic [XLEN-1:0]      id_rt_val,
  output logic [XLEN-1:0]      id_imm,
  output logic [AW-1:0]        id_dest,
  output logic                 redirect_valid,
  output logic [XLEN-1:0]      redirect_pc,
  input  logic [AW-1:0]        dbg_sel,
  output logic [XLEN-1:0]      dbg_data,
  output logic [31:0]          stall_cnt,
  output logic [31:0]          flush_cnt
);

  logic [XLEN-1:0] rf [NREG];
  dec_t            dec;
  logic [AW-1:0]   rs_idx, rt_idx;
  logic [XLEN-1:0] rs_base, rt_base, rs_op, rt_op;
  logic [XLEN:0]   rs_res, rt_res;
  logic [XLEN-1:0] imm_sext, br_tgt, jmp_tgt;
  logic            hazard, fire_in, fire_out, taken;

  // Youngest matching forward source wins; msb of the result flags a pending value.
  function automatic logic [XLEN:0] resolve(
    input logic [AW-1:0]        r,
    input logic [NFWD-1:0]      wen,
    input logic [NFWD-1:0]      pend,
    input logic [NFWD*AW-1:0]   dest,
    input logic [NFWD*XLEN-1:0] data,
    input logic [XLEN-1:0]      base
  );
    logic hit;
    logic [XLEN:0] res;
    hit = 1'b0;
    res = {1'b0, base};
    for (int unsigned i = 0; i < NFWD; i++) begin
      if (!hit && wen[i] && dest[i*AW +: AW] == r) begin
        hit = 1'b1;
        res = {pend[i], data[i*XLEN +: XLEN]};
      end
    end
    if (r == '0) res = '0;
    return res;
  endfunction

  id_decode u_dec (
    .op    (id_inst[31:26]),
    .funct (id_inst[5:0]),
    .rt    (id_inst[20:16]),
    .rd    (id_inst[15:11]),
    .dec   (dec)
  );

  assign rs_idx  = AW'(id_inst[25:21]);
  assign rt_idx  = AW'(id_inst[20:16]);
  assign rs_base = (wb_wen && wb_dest == rs_idx) ? wb_data : rf[rs_idx];
  assign rt_base = (wb_wen && wb_dest == rt_idx) ? wb_data : rf[rt_idx];
  assign rs_res  = resolve(rs_idx, fwd_wen, fwd_pend, fwd_dest, fwd_data, rs_base);
  assign rt_res  = resolve(rt_idx, fwd_wen, fwd_pend, fwd_dest, fwd_data, rt_base);
  assign rs_op   = dec.uses_rs ? rs_res[XLEN-1:0] : '0;
  assign rt_op   = dec.uses_rt ? rt_res[XLEN-1:0] : '0;
  assign hazard  = (dec.uses_rs & rs_res[XLEN]) | (dec.uses_rt & rt_res[XLEN]);

  assign fire_in  = if_valid & if_ready;
  assign fire_out = id_valid & ex_ready & ~hazard;
  assign if_ready = ~id_valid | fire_out;

  assign imm_sext  = {{(XLEN-16){id_inst[15]}}, id_inst[15:0]};
  assign id_imm    = dec.sext ? imm_sext : {{(XLEN-16){1'b0}}, id_inst[15:0]};
  assign id_dest   = AW'(dec.dest);
  assign id_rs_val = dec.jal ? id_pc4 : rs_op;
  assign id_rt_val = rt_op;

  assign br_tgt  = id_pc4 + (imm_sext << 2);
  assign jmp_tgt = {id_pc4[XLEN-1:28], id_inst[25:0], 2'b00};
  assign taken   = (dec.br & (rs_op == rt_op)) | (dec.bne & (rs_op != rt_op)) |
                   dec.j | dec.jal | dec.jr;

  assign redirect_valid = fire_out & taken;
  assign redirect_pc    = dec.jr ? rs_op : ((dec.j | dec.jal) ? jmp_tgt : br_tgt);
  assign dbg_data       = rf[dbg_sel];

  // IF/ID register; an instruction accepted alongside a redirect is squashed
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      id_valid <= 1'b0;
      id_inst  <= '0;
      id_pc4   <= '0;
    end else if (fire_in && !redirect_valid) begin
      id_valid <= 1'b1;
      id_inst  <= if_inst;
      id_pc4   <= if_pc4;
    end else if (fire_out) begin
      id_valid <= 1'b0;
    end
  end

  // Register file write port; register 0 stays zero
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NREG; i++) rf[i] <= '0;
    end else if (wb_wen && wb_dest != '0) begin
      rf[wb_dest] <= wb_data;
    end
  end

  // Saturating stall and flush counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (id_valid && hazard && stall_cnt != '1) stall_cnt <= stall_cnt + 32'd1;
      if (redirect_valid && flush_cnt != '1)     flush_cnt <= flush_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_id_stage_fwd.sv
// Directed bench for id_stage_fwd: vector table plus multi-cycle sequences.
module tb_id_stage_fwd;

  logic        clk, rst;
  logic        if_valid, if_ready;
  logic [31:0] if_inst, if_pc4;
  logic        id_valid, ex_ready;
  logic [2:0]  fwd_wen, fwd_pend;
  logic [14:0] fwd_dest;
  logic [95:0] fwd_data;
  logic        wb_wen;
  logic [4:0]  wb_dest;
  logic [31:0] wb_data;
  logic [31:0] id_inst, id_pc4, id_rs_val, id_rt_val, id_imm;
  logic [4:0]  id_dest;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [4:0]  dbg_sel;
  logic [31:0] dbg_data, stall_cnt, flush_cnt;

  int tests = 0;
  int fails = 0;
  int exp_stall = 0;
  int exp_flush = 0;

  id_stage_fwd dut (
    .clk(clk), .rst(rst),
    .if_valid(if_valid), .if_ready(if_ready), .if_inst(if_inst), .if_pc4(if_pc4),
    .id_valid(id_valid), .ex_ready(ex_ready),
    .fwd_wen(fwd_wen), .fwd_pend(fwd_pend), .fwd_dest(fwd_dest), .fwd_data(fwd_data),
    .wb_wen(wb_wen), .wb_dest(wb_dest), .wb_data(wb_data),
    .id_inst(id_inst), .id_pc4(id_pc4), .id_rs_val(id_rs_val), .id_rt_val(id_rt_val),
    .id_imm(id_imm), .id_dest(id_dest),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .dbg_sel(dbg_sel), .dbg_data(dbg_data),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc4;
    logic [2:0]  wen;
    logic [2:0]  pend;
    logic [14:0] dest;
    logic [95:0] data;
    logic        wbw;
    logic [4:0]  wbd;
    logic [31:0] wbv;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] imm;
    logic [4:0]  dst;
    logic        redir;
    logic [31:0] rpc;
  } vec_t;

  localparam int NV = 19;
  vec_t v [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clear_side();
    fwd_wen  = 3'b000;
    fwd_pend = 3'b000;
    fwd_dest = 15'h0;
    fwd_data = 96'h0;
    wb_wen   = 1'b0;
    wb_dest  = 5'd0;
    wb_data  = 32'h0;
    ex_ready = 1'b0;
  endtask

  // Present one instruction for a single edge; returns at the following negedge
  task automatic load_inst(input logic [31:0] inst, input logic [31:0] pc4);
    @(negedge clk);
    clear_side();
    if_valid = 1'b1;
    if_inst  = inst;
    if_pc4   = pc4;
    @(negedge clk);
    if_valid = 1'b0;
  endtask

  task automatic wb_write(input logic [4:0] r, input logic [31:0] val);
    @(negedge clk);
    wb_wen  = 1'b1;
    wb_dest = r;
    wb_data = val;
  endtask

  initial begin
    v[0]  = '{32'h00A01820, 32'h1000, 3'b011, 3'b000, 15'h00A5, {32'h0, 32'hB, 32'hA}, 1'b0, 5'd0, 32'h0, 32'hA, 32'h0, 32'h1820, 5'd3, 1'b0, 32'h0};
    v[1]  = '{32'h00A01820, 32'h1000, 3'b011, 3'b010, 15'h00A5, {32'h0, 32'hB, 32'hA}, 1'b0, 5'd0, 32'h0, 32'hA, 32'h0, 32'h1820, 5'd3, 1'b0, 32'h0};
    v[2]  = '{32'h00A01820, 32'h1000, 3'b110, 3'b100, 15'h14A5, {32'hC, 32'hB, 32'hA}, 1'b0, 5'd0, 32'h0, 32'hB, 32'h0, 32'h1820, 5'd3, 1'b0, 32'h0};
    v[3]  = '{32'h00222020, 32'h1000, 3'b000, 3'b000, 15'h0000, 96'h0, 1'b0, 5'd0, 32'h0, 32'h11, 32'h22, 32'h2020, 5'd4, 1'b0, 32'h0};
    v[4]  = '{32'h00051820, 32'h1000, 3'b001, 3'b000, 15'h0000, {32'h0, 32'h0, 32'hDEAD}, 1'b0, 5'd0, 32'h0, 32'h0, 32'h500, 32'h1820, 5'd3, 1'b0, 32'h0};
    v[5]  = '{32'h34268001, 32'h1000, 3'b000, 3'b000, 15'h0000, 96'h0, 1'b0, 5'd0, 32'h0, 32'h11, 32'h0, 32'h00008001, 5'd6, 1'b0, 32'h0};
    v[6]  = '{32'h2026FFFF, 32'h1000, 3'b000, 3'b000, 15'h0000, 96'h0, 1'b0, 5'd0, 32'h0, 32'h11, 32'h0, 32'hFFFFFFFF, 5'd6, 1'b0, 32'h0};
    v[7]  = '{32'h8C480004, 32'h1000, 3'b000, 3'b000, 15'h0000, 96'h0, 1'b0, 5'd0, 32'h0, 32'h22, 32'h0, 32'h4, 5'd8, 1'b0, 32'h0};
    v[8]  = '{32'hAC410008, 32'h1000, 3'b000, 3'b000, 15'h0000, 96'h0, 1'b0, 5'd0, 32'h0, 32'h22, 32'h11, 32'h8, 5'd0, 1'b0, 32'h0};
    v[9]  = '{32'h10E7FFFF, 32'h100, 3'b000, 3'b000, 15'h0000, 96'h0, 1'b0, 5'd0, 32'h0, 32'h77, 32'h77, 32'hFFFFFFFF, 5'd0, 1'b1, 32'hFC};
    v[10] = '{32'h14220003, 32'h200, 3'b000, 3'b000, 15'h0000, 96'h0, 1'b0, 5'd0, 32'h0, 32'h11, 32'h22, 32'h3, 5'd0, 1'b1, 32'h20C};
    v[11] = '{32'h14E70003, 32'h300, 3'b000, 3'b000, 15'h0000, 96'h0, 1'b0, 5'd0, 32'h0, 32'h77, 32'h77, 32'h3, 5'd0, 1'b0, 32'h0};
    v[12] = '{32'h0C000010, 32'h40000010, 3'b000, 3'b000, 15'h0000, 96'h0, 1'b0, 5'd0, 32'h0, 32'h40000010, 32'h0, 32'h10, 5'd31, 1'b1, 32'h40000040};
    v[13] = '{32'h08000100, 32'h80000004, 3'b000, 3'b000, 15'h0000, 96'h0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h100, 5'd0, 1'b1, 32'h80000400};
    v[14] = '{32'h00A00008, 32'h1000, 3'b001, 3'b000, 15'h0005, {32'h0, 32'h0, 32'h1234}, 1'b0, 5'd0, 32'h0, 32'h1234, 32'h0, 32'h8, 5'd0, 1'b1, 32'h1234};
    v[15] = '{32'h01205020, 32'h1000, 3'b000, 3'b000, 15'h0000, 96'h0, 1'b1, 5'd9, 32'h55, 32'h55, 32'h0, 32'h5020, 5'd10, 1'b0, 32'h0};
    v[16] = '{32'h00005020, 32'h1000, 3'b000, 3'b000, 15'h0000, 96'h0, 1'b1, 5'd0, 32'hFF, 32'h0, 32'h0, 32'h5020, 5'd10, 1'b0, 32'h0};
    v[17] = '{32'h01205020, 32'h1000, 3'b100, 3'b000, 15'h2400, {32'h77, 32'h0, 32'h0}, 1'b1, 5'd9, 32'h66, 32'h77, 32'h0, 32'h5020, 5'd10, 1'b0, 32'h0};
    v[18] = '{32'h00222020, 32'h1000, 3'b100, 3'b000, 15'h0800, {32'h99, 32'h0, 32'h0}, 1'b0, 5'd0, 32'h0, 32'h11, 32'h99, 32'h2020, 5'd4, 1'b0, 32'h0};

    rst = 1'b0;
    if_valid = 1'b0; if_inst = 32'h0; if_pc4 = 32'h0; dbg_sel = 5'd0;
    clear_side();

    // Reset state
    #1;
    chk("rst id_valid", 32'(id_valid), 32'd0);
    chk("rst if_ready", 32'(if_ready), 32'd1);
    chk("rst redirect_valid", 32'(redirect_valid), 32'd0);
    chk("rst rs_val", id_rs_val, 32'h0);
    chk("rst rt_val", id_rt_val, 32'h0);
    chk("rst imm", id_imm, 32'h0);
    chk("rst dest", 32'(id_dest), 32'd0);
    chk("rst stall_cnt", stall_cnt, 32'd0);
    chk("rst flush_cnt", flush_cnt, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    wb_write(5'd1, 32'h11);
    wb_write(5'd2, 32'h22);
    wb_write(5'd5, 32'h500);
    wb_write(5'd7, 32'h77);
    @(negedge clk);
    wb_wen = 1'b0;

    // Table: load, apply side inputs with ex_ready high, compare, let it fire out
    for (int i = 0; i < NV; i++) begin
      load_inst(v[i].inst, v[i].pc4);
      fwd_wen  = v[i].wen;
      fwd_pend = v[i].pend;
      fwd_dest = v[i].dest;
      fwd_data = v[i].data;
      wb_wen   = v[i].wbw;
      wb_dest  = v[i].wbd;
      wb_data  = v[i].wbv;
      ex_ready = 1'b1;
      #1;
      chk($sformatf("v%0d id_valid", i), 32'(id_valid), 32'd1);
      chk($sformatf("v%0d rs_val", i), id_rs_val, v[i].rs);
      chk($sformatf("v%0d rt_val", i), id_rt_val, v[i].rt);
      chk($sformatf("v%0d imm", i), id_imm, v[i].imm);
      chk($sformatf("v%0d dest", i), 32'(id_dest), 32'(v[i].dst));
      chk($sformatf("v%0d if_ready", i), 32'(if_ready), 32'd1);
      chk($sformatf("v%0d redirect_valid", i), 32'(redirect_valid), 32'(v[i].redir));
      if (v[i].redir) begin
        chk($sformatf("v%0d redirect_pc", i), redirect_pc, v[i].rpc);
        exp_flush++;
      end
    end
    @(negedge clk);
    clear_side();
    chk("table flush_cnt", flush_cnt, 32'(exp_flush));
    chk("table drained", 32'(id_valid), 32'd0);

    // Load-use hazard: held while pending, fires the cycle it clears
    load_inst(32'h00A01820, 32'h2000);
    fwd_wen = 3'b001; fwd_pend = 3'b001; fwd_dest = 15'h0005; fwd_data = {32'h0, 32'h0, 32'hBAD};
    ex_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("lu%0d if_ready", k), 32'(if_ready), 32'd0);
      chk($sformatf("lu%0d id_valid", k), 32'(id_valid), 32'd1);
      chk($sformatf("lu%0d redirect_valid", k), 32'(redirect_valid), 32'd0);
      chk($sformatf("lu%0d stall_cnt", k), stall_cnt, 32'(exp_stall));
      @(negedge clk);
      exp_stall++;
    end
    fwd_pend = 3'b000; fwd_data = {32'h0, 32'h0, 32'hCAFE};
    #1;
    chk("lu release if_ready", 32'(if_ready), 32'd1);
    chk("lu release rs_val", id_rs_val, 32'hCAFE);
    chk("lu stall_cnt", stall_cnt, 32'(exp_stall));
    @(negedge clk);
    chk("lu emitted", 32'(id_valid), 32'd0);
    chk("lu stall_cnt after", stall_cnt, 32'(exp_stall));

    // ex_ready low without hazard: held, no stall counted
    load_inst(32'h00222020, 32'h2100);
    #1;
    chk("hold if_ready", 32'(if_ready), 32'd0);
    @(negedge clk);
    @(negedge clk);
    chk("hold id_valid", 32'(id_valid), 32'd1);
    chk("hold stall_cnt", stall_cnt, 32'(exp_stall));
    ex_ready = 1'b1;
    @(negedge clk);
    chk("hold emitted", 32'(id_valid), 32'd0);

    // Taken beq squashes the instruction fetched in the same cycle
    load_inst(32'h10E7FFFF, 32'h100);
    ex_ready = 1'b1;
    if_valid = 1'b1; if_inst = 32'h00222020; if_pc4 = 32'h104;
    #1;
    chk("sq redirect_valid", 32'(redirect_valid), 32'd1);
    chk("sq redirect_pc", redirect_pc, 32'hFC);
    chk("sq if_ready", 32'(if_ready), 32'd1);
    exp_flush++;
    @(negedge clk);
    if_valid = 1'b0;
    chk("sq id_valid", 32'(id_valid), 32'd0);
    chk("sq flush_cnt", flush_cnt, 32'(exp_flush));

    // Register-file peek
    dbg_sel = 5'd9; #1; chk("dbg r9", dbg_data, 32'h66);
    dbg_sel = 5'd0; #1; chk("dbg r0", dbg_data, 32'h0);
    dbg_sel = 5'd7; #1; chk("dbg r7", dbg_data, 32'h77);
    dbg_sel = 5'd5; #1; chk("dbg r5", dbg_data, 32'h500);

    // Async reset during a stall clears state without a clock edge
    load_inst(32'h00A01820, 32'h3000);
    fwd_wen = 3'b001; fwd_pend = 3'b001; fwd_dest = 15'h0005;
    ex_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    exp_stall += 2;
    chk("ar pre stall_cnt", stall_cnt, 32'(exp_stall));
    #2;
    rst = 1'b0;
    #1;
    chk("ar id_valid", 32'(id_valid), 32'd0);
    chk("ar stall_cnt", stall_cnt, 32'd0);
    chk("ar flush_cnt", flush_cnt, 32'd0);
    chk("ar if_ready", 32'(if_ready), 32'd1);
    chk("ar dbg r5", dbg_data, 32'h0);
    chk("ar rs_val", id_rs_val, 32'h0);
    clear_side();
    if_valid = 1'b1; if_inst = 32'h00222020; if_pc4 = 32'h4000;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    if_valid = 1'b0;
    chk("ar first accept valid", 32'(id_valid), 32'd1);
    chk("ar first accept inst", id_inst, 32'h00222020);
    chk("ar first accept pc4", id_pc4, 32'h4000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
